entropy_decoder_byte_feeder: RTL and testbench

- Byte-level input buffer at the head of the AV1 arithmetic decoder.
- Accepts the encoder's packed bitstream output format: up to 5 bytes per cycle, a 3-bit byte count and a last flag.
- Stores the bytes in a circular buffer and serves 1–2 bytes per request to the decoder refill logic.
- Once the stream has ended and the buffer is empty, it supplies pad bytes.

---
 rtl/entropy_decoder_byte_feeder.sv | 194 +++++++++++++++++++
 tb/tb_entropy_decoder_byte_feeder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/entropy_decoder_byte_feeder.sv
// Byte feeder in front of the AV1 arithmetic decoder: circular byte buffer
// with 0-5 byte writes per cycle, 1-2 byte registered reads and padding at end of stream.
module entropy_decoder_byte_feeder #(
    parameter int                             TOP_BITSTREAM_WIDTH = 8,
    parameter int                             FB_DEPTH            = 32,
    parameter int                             FB_PTR_WIDTH        = 5,
    parameter logic [TOP_BITSTREAM_WIDTH-1:0] FB_PAD_BYTE         = 8'h00
) (
    input  logic                           top_clk,
    input  logic                           top_reset,
    input  logic                           in_flag_first,
    input  logic [TOP_BITSTREAM_WIDTH-1:0] in_bit_1,
    input  logic [TOP_BITSTREAM_WIDTH-1:0] in_bit_2,
    input  logic [TOP_BITSTREAM_WIDTH-1:0] in_bit_3,
    input  logic [TOP_BITSTREAM_WIDTH-1:0] in_bit_4,
    input  logic [TOP_BITSTREAM_WIDTH-1:0] in_bit_5,
    input  logic [2:0]                     in_flag_bitstream,
    input  logic                           in_flag_last,
    output logic                           in_ready,
    input  logic                           rd_en,
    input  logic [1:0]                     rd_cnt,
    output logic [TOP_BITSTREAM_WIDTH-1:0] out_byte_1,
    output logic [TOP_BITSTREAM_WIDTH-1:0] out_byte_2,
    output logic [1:0]                     out_valid,
    output logic                           out_pad,
    output logic                           out_end,
    output logic                           out_overflow,
    output logic [FB_PTR_WIDTH:0]          out_level
);

    localparam int W  = TOP_BITSTREAM_WIDTH;
    localparam int LW = FB_PTR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [W-1:0]            r_mem [FB_DEPTH];
    logic [FB_PTR_WIDTH-1:0] r_wr_ptr;
    logic [FB_PTR_WIDTH-1:0] r_rd_ptr;
    logic [LW-1:0]           r_level;
    logic [W-1:0]            r_byte_1;
    logic [W-1:0]            r_byte_2;
    logic [1:0]              r_valid;
    logic                    r_pad;
    logic                    r_end;
    logic                    r_overflow;

    logic [5*W-1:0]          w_in_flat;
    logic [W-1:0]            w_in_bytes [5];
    logic [LW-1:0]           w_free;
    logic                    w_ready;
    logic [2:0]              w_wr_cnt;
    logic                    w_wr_en;
    logic                    w_drop;
    logic [FB_PTR_WIDTH-1:0] w_wr_base;
    logic                    w_rd_active;
    logic                    w_padding;
    logic [1:0]              w_req;
    logic [1:0]              w_take;
    logic                    w_pad_any;
    logic [W-1:0]            w_rd_data_0;
    logic [W-1:0]            w_rd_data_1;
    logic [W-1:0]            w_byte_1_next;
    logic [W-1:0]            w_byte_2_next;
    logic [1:0]              w_valid_next;
    logic [FB_PTR_WIDTH-1:0] w_wr_ptr_next;
    logic [FB_PTR_WIDTH-1:0] w_rd_ptr_next;
    logic [LW-1:0]           w_level_next;

    assign w_in_flat = {in_bit_5, in_bit_4, in_bit_3, in_bit_2, in_bit_1};

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_in_bytes
            assign w_in_bytes[gi] = w_in_flat[gi*W +: W];
        end
    endgenerate

    assign w_free   = LW'(FB_DEPTH) - r_level;
    assign w_ready  = (w_free >= LW'(5));
    assign w_wr_cnt = (in_flag_bitstream > 3'd5) ? 3'd5 : in_flag_bitstream;

    // A restart empties the buffer first, so its data always fits.
    assign w_wr_en   = (w_wr_cnt != 3'd0) &&
                       (in_flag_first || (r_state == S_STREAM && w_ready));
    assign w_drop    = !in_flag_first && (r_state == S_STREAM) &&
                       (w_wr_cnt != 3'd0) && !w_ready;
    assign w_wr_base = in_flag_first ? '0 : r_wr_ptr;

    assign w_rd_active = rd_en && !in_flag_first && (r_state != S_IDLE);
    assign w_padding   = (r_state == S_DRAIN) || (r_state == S_DONE);
    assign w_req       = (rd_cnt == 2'd2) ? 2'd2 : 2'd1;
    assign w_take      = (r_level >= LW'(w_req)) ? w_req : r_level[1:0];
    assign w_pad_any   = w_rd_active && w_padding && (w_take < w_req);

    assign w_rd_data_0 = r_mem[r_rd_ptr];
    assign w_rd_data_1 = r_mem[r_rd_ptr + FB_PTR_WIDTH'(1)];

    always_comb begin
        w_byte_1_next = r_byte_1;
        w_byte_2_next = r_byte_2;
        w_valid_next  = 2'd0;
        if (w_rd_active) begin
            w_valid_next = w_padding ? w_req : w_take;
            if (w_take >= 2'd1)
                w_byte_1_next = w_rd_data_0;
            else
                w_byte_1_next = w_padding ? FB_PAD_BYTE : '0;
            if (w_req != 2'd2)
                w_byte_2_next = '0;
            else if (w_take == 2'd2)
                w_byte_2_next = w_rd_data_1;
            else
                w_byte_2_next = w_padding ? FB_PAD_BYTE : '0;
        end
    end

    always_comb begin
        w_wr_ptr_next = w_wr_base + (w_wr_en ? FB_PTR_WIDTH'(w_wr_cnt) : '0);
        w_rd_ptr_next = in_flag_first ? '0 : r_rd_ptr;
        w_level_next  = in_flag_first ? '0 : r_level;
        if (w_rd_active) begin
            w_rd_ptr_next = r_rd_ptr + FB_PTR_WIDTH'(w_take);
            w_level_next  = r_level - LW'(w_take);
        end
        if (w_wr_en)
            w_level_next = w_level_next + LW'(w_wr_cnt);
    end

    always_comb begin
        w_state_next = r_state;
        if (in_flag_first) begin
            w_state_next = in_flag_last ? S_DRAIN : S_STREAM;
        end else begin
            case (r_state)
                S_STREAM: if (in_flag_last) w_state_next = S_DRAIN;
                S_DRAIN:  if (w_pad_any)    w_state_next = S_DONE;
                default:  w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge top_clk) begin
        if (!top_reset) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_byte_1   <= '0;
            r_byte_2   <= '0;
            r_valid    <= 2'd0;
            r_pad      <= 1'b0;
            r_end      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_level    <= w_level_next;
            r_byte_1   <= w_byte_1_next;
            r_byte_2   <= w_byte_2_next;
            r_valid    <= w_valid_next;
            r_pad      <= w_pad_any;
            r_end      <= (w_state_next == S_DONE);
            r_overflow <= in_flag_first ? 1'b0 : (r_overflow | w_drop);
        end
    end

    // Storage carries no reset; pointers and level define what is valid.
    always_ff @(posedge top_clk) begin
        if (top_reset && w_wr_en) begin
            for (int i = 0; i < 5; i++) begin
                if (3'(i) < w_wr_cnt)
                    r_mem[w_wr_base + FB_PTR_WIDTH'(i)] <= w_in_bytes[i];
            end
        end
    end

    assign in_ready     = w_ready;
    assign out_byte_1   = r_byte_1;
    assign out_byte_2   = r_byte_2;
    assign out_valid    = r_valid;
    assign out_pad      = r_pad;
    assign out_end      = r_end;
    assign out_overflow = r_overflow;
    assign out_level    = r_level;

endmodule

// File: tb/tb_entropy_decoder_byte_feeder.sv
// Randomized bench for entropy_decoder_byte_feeder, checked every cycle against
// a queue-based model of the stream buffer.
module tb_entropy_decoder_byte_feeder;

    logic       top_clk;
    logic       top_reset;
    logic       in_flag_first;
    logic [7:0] in_bit_1, in_bit_2, in_bit_3, in_bit_4, in_bit_5;
    logic [2:0] in_flag_bitstream;
    logic       in_flag_last;
    logic       in_ready;
    logic       rd_en;
    logic [1:0] rd_cnt;
    logic [7:0] out_byte_1, out_byte_2;
    logic [1:0] out_valid;
    logic       out_pad, out_end, out_overflow;
    logic [5:0] out_level;

    entropy_decoder_byte_feeder dut (
        .top_clk           (top_clk),
        .top_reset         (top_reset),
        .in_flag_first     (in_flag_first),
        .in_bit_1          (in_bit_1),
        .in_bit_2          (in_bit_2),
        .in_bit_3          (in_bit_3),
        .in_bit_4          (in_bit_4),
        .in_bit_5          (in_bit_5),
        .in_flag_bitstream (in_flag_bitstream),
        .in_flag_last      (in_flag_last),
        .in_ready          (in_ready),
        .rd_en             (rd_en),
        .rd_cnt            (rd_cnt),
        .out_byte_1        (out_byte_1),
        .out_byte_2        (out_byte_2),
        .out_valid         (out_valid),
        .out_pad           (out_pad),
        .out_end           (out_end),
        .out_overflow      (out_overflow),
        .out_level         (out_level)
    );

    initial top_clk = 1'b0;
    always #5 top_clk = ~top_clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Reference model: the buffer is a byte queue, the stream phase a small enum.
    typedef enum int {M_IDLE, M_STREAM, M_DRAIN, M_DONE} mode_t;
    mode_t      m_mode = M_IDLE;
    logic [7:0] m_q[$];
    bit         m_ovf = 0, m_end = 0, e_pad = 0;
    int         e_valid = 0;
    logic [7:0] e_b1 = 0, e_b2 = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL cyc%0d %s: got %0h expected %0h", cyc, tag, got, exp);
    endtask

    task automatic model_step(input bit rst_n, input bit first, input int cnt, input bit last,
                              input bit rd, input int rcnt, input logic [7:0] b[5]);
        int pre_level, req, k;
        logic [7:0] v[2];
        pre_level = m_q.size();
        if (!rst_n) begin
            m_q.delete();
            m_mode = M_IDLE; m_ovf = 0; m_end = 0;
            e_b1 = 0; e_b2 = 0; e_valid = 0; e_pad = 0;
            return;
        end
        if (rd && !first && m_mode != M_IDLE) begin
            req = (rcnt == 2) ? 2 : 1;
            k   = (pre_level < req) ? pre_level : req;
            for (int j = 0; j < 2; j++) begin
                if (j < k) v[j] = m_q.pop_front();
                else v[j] = 8'h00;   // padding and unused slots are both zero
            end
            e_b1 = v[0]; e_b2 = v[1];
            e_valid = (m_mode == M_STREAM) ? k : req;
            e_pad   = (m_mode != M_STREAM) && (k < req);
            if (e_pad && m_mode == M_DRAIN) m_mode = M_DONE;
        end else begin
            e_valid = 0; e_pad = 0;
        end
        if (first) begin
            m_q.delete();
            m_ovf = 0;
            for (int j = 0; j < cnt; j++) m_q.push_back(b[j]);
            m_mode = last ? M_DRAIN : M_STREAM;
        end else if (m_mode == M_STREAM) begin
            if (cnt > 0) begin
                if (32 - pre_level >= 5) for (int j = 0; j < cnt; j++) m_q.push_back(b[j]);
                else m_ovf = 1;
            end
            if (last) m_mode = M_DRAIN;
        end
        m_end = (m_mode == M_DONE);
    endtask

    task automatic cycle(input bit rst_n, input bit first, input int cnt, input bit last,
                         input bit rd, input int rcnt, input logic [7:0] b[5]);
        top_reset = rst_n; in_flag_first = first; in_flag_bitstream = 3'(cnt);
        in_flag_last = last; rd_en = rd; rd_cnt = 2'(rcnt);
        in_bit_1 = b[0]; in_bit_2 = b[1]; in_bit_3 = b[2]; in_bit_4 = b[3]; in_bit_5 = b[4];
        @(posedge top_clk);
        #1;
        cyc++;
        model_step(rst_n, first, cnt, last, rd, rcnt, b);
        check("level",    int'(out_level),    m_q.size());
        check("in_ready", int'(in_ready),     int'((32 - m_q.size()) >= 5));
        check("overflow", int'(out_overflow), int'(m_ovf));
        check("end",      int'(out_end),      int'(m_end));
        check("valid",    int'(out_valid),    e_valid);
        check("pad",      int'(out_pad),      int'(e_pad));
        check("byte_1",   int'(out_byte_1),   int'(e_b1));
        check("byte_2",   int'(out_byte_2),   int'(e_b2));
    endtask

    task automatic rnd_cycle(input bit rst_n, input bit first, input int cnt, input bit last,
                             input bit rd, input int rcnt);
        logic [7:0] b[5];
        for (int j = 0; j < 5; j++) b[j] = 8'($urandom_range(1, 255));
        cycle(rst_n, first, cnt, last, rd, rcnt, b);
    endtask

    initial begin
        logic [7:0] b[5];
        top_reset = 0; in_flag_first = 0; in_flag_bitstream = 0; in_flag_last = 0;
        rd_en = 0; rd_cnt = 0;
        in_bit_1 = 0; in_bit_2 = 0; in_bit_3 = 0; in_bit_4 = 0; in_bit_5 = 0;

        // Reset, then first write {A1,B2,C3} and a 2-byte read
        rnd_cycle(0, 0, 0, 0, 0, 0);
        b = '{8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00};
        cycle(1, 1, 3, 0, 0, 0, b);
        rnd_cycle(1, 0, 0, 0, 1, 2);
        check("first_b1", int'(out_byte_1), 'hA1);
        check("first_lvl", int'(out_level), 1);

        // Fill to 30, then an overflowing write
        rnd_cycle(1, 1, 5, 0, 0, 0);
        repeat (5) rnd_cycle(1, 0, 5, 0, 0, 0);
        check("full_ready", int'(in_ready), 0);
        rnd_cycle(1, 0, 5, 0, 0, 0);
        check("ovf_set", int'(out_overflow), 1);
        check("ovf_lvl", int'(out_level), 30);

        // Alternate write 5 / read 2 across several pointer wraps
        rnd_cycle(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            rnd_cycle(1, 0, 5, 0, 0, 0);
            repeat (3) rnd_cycle(1, 0, 0, 0, 1, 2);
        end
        repeat (40) rnd_cycle(1, 0, 0, 0, 1, 2);   // drain, then underrun in STREAM

        // One byte buffered, request 2: short read, no padding
        rnd_cycle(1, 0, 1, 0, 0, 0);
        rnd_cycle(1, 0, 0, 0, 1, 2);
        check("short_valid", int'(out_valid), 1);

        // End of stream: {11,22,33} with last, then two 2-byte reads
        rnd_cycle(1, 1, 0, 0, 0, 0);
        b = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00};
        cycle(1, 0, 3, 1, 0, 0, b);
        rnd_cycle(1, 0, 0, 0, 1, 2);
        check("eos_end_early", int'(out_end), 0);
        rnd_cycle(1, 0, 0, 0, 1, 2);
        check("eos_b1", int'(out_byte_1), 'h33);
        check("eos_pad", int'(out_pad), 1);
        rnd_cycle(1, 0, 0, 0, 0, 0);
        check("eos_end", int'(out_end), 1);
        rnd_cycle(1, 0, 5, 0, 1, 1);                 // writes ignored after end

        // Mid-stream reset with 12 bytes, then writes ignored until first
        rnd_cycle(1, 1, 5, 0, 0, 0);
        rnd_cycle(1, 0, 5, 0, 0, 0);
        rnd_cycle(1, 0, 2, 0, 0, 0);
        check("pre_rst_lvl", int'(out_level), 12);
        rnd_cycle(0, 0, 0, 0, 0, 0);
        rnd_cycle(1, 0, 5, 0, 1, 2);
        check("idle_lvl", int'(out_level), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            rnd_cycle($urandom_range(0, 299) != 0, $urandom_range(0, 79) == 0,
                      $urandom_range(0, 5), $urandom_range(0, 59) == 0,
                      1'($urandom_range(0, 1)), $urandom_range(0, 3));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
